// File: rtl/sc_pkg.sv
// Shared encodings for the single-cycle instruction-fetch stage: next-PC
// selector values, fetch FSM states and the default reset PC.
package sc_pkg;

    typedef enum logic [1:0] {
        PCS_SEQ = 2'b00,
        PCS_BR  = 2'b01,
        PCS_JR  = 2'b10,
        PCS_J   = 2'b11
    } pcsource_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_VALID = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sc_ifetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and a variable-latency instruction memory (slave).
interface sc_ifetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/sc_npc_mux.sv
// Combinational next-PC select from the control unit's pcsource, plus a flag
// for a selected target that is not word aligned.
module sc_npc_mux
    import sc_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] npc,
    output logic        npc_bad
);

    always_comb begin
        npc = pc4;
        case (pcsource_t'(pcsource))
            PCS_SEQ: npc = pc4;
            PCS_BR:  npc = bpc;
            PCS_JR:  npc = rpc;
            PCS_J:   npc = jpc;
            default: npc = pc4;
        endcase
    end

    assign npc_bad = (npc[1:0] != 2'b00);

endmodule

// File: rtl/sc_ifetch.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction over
// a req/ack memory handshake and advances the PC when the datapath commits.
module sc_ifetch
    import sc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    sc_ifetch_if.master      imem,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc4,
    input  logic             commit,
    input  logic [1:0]       pcsource,
    input  logic [31:0]      bpc,
    input  logic [31:0]      rpc,
    input  logic [31:0]      jpc,
    output logic             misalign,
    output logic [CNT_W-1:0] retired
);

    state_t      state;
    state_t      state_next;
    logic [31:0] npc;
    logic        npc_bad;
    logic        fetch_done;
    logic        retire;

    sc_npc_mux u_npc_mux (
        .pcsource (pcsource),
        .pc4      (pc4),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .npc      (npc),
        .npc_bad  (npc_bad)
    );

    assign pc4       = pc + 32'd4;
    assign imem.addr = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Acks outside FETCH and commits without a valid instruction are dropped here.
    always_comb begin
        state_next = state;
        imem.req   = 1'b0;
        fetch_done = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    fetch_done = 1'b1;
                    state_next = ST_VALID;
                end
            end
            ST_VALID: begin
                if (commit && inst_valid) begin
                    retire     = 1'b1;
                    state_next = npc_bad ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            inst       <= 32'h0000_0000;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            retired    <= '0;
        end else begin
            if (fetch_done) begin
                inst       <= imem.rdata;
                inst_valid <= 1'b1;
            end
            if (retire) begin
                inst_valid <= 1'b0;
                retired    <= retired + CNT_W'(1);
                // A misaligned target halts with the PC left on the offending instruction.
                if (npc_bad) begin
                    misalign <= 1'b1;
                end else begin
                    pc <= npc;
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_ifetch.sv
// Directed bench for sc_ifetch: reset, variable-latency fetch, PC redirection,
// misalign halt, reset during fetch and ignored stray handshakes.
module tb_sc_ifetch;

    logic        clock;
    logic        reset;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        commit;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic        misalign;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    sc_ifetch_if imem ();

    sc_ifetch #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .imem       (imem.master),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc4        (pc4),
        .commit     (commit),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .misalign   (misalign),
        .retired    (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b1;
        commit     = 1'b0;
        pcsource   = 2'b00;
        bpc        = 32'h0;
        rpc        = 32'h0;
        jpc        = 32'h0;
        imem.ack   = 1'b0;
        imem.rdata = 32'h0;

        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_req", {31'b0, imem.req}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
        check("rst_retired", retired, 32'h0);

        // BOOT -> FETCH, then ack in the first FETCH cycle
        reset = 1'b0;
        step();
        check("t1_req", {31'b0, imem.req}, 32'h1);
        check("t1_addr", imem.addr, 32'h0);
        check("t1_valid_pre", {31'b0, inst_valid}, 32'h0);
        imem.ack   = 1'b1;
        imem.rdata = 32'h2008_0005;
        step();
        imem.ack   = 1'b0;
        check("t1_valid", {31'b0, inst_valid}, 32'h1);
        check("t1_inst", inst, 32'h2008_0005);
        check("t1_pc", pc, 32'h0);
        check("t1_pc4", pc4, 32'h4);
        check("t1_req_drop", {31'b0, imem.req}, 32'h0);

        // Stray ack while VALID
        imem.ack   = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        step();
        imem.ack = 1'b0;
        check("t6_stray_ack_inst", inst, 32'h2008_0005);
        check("t6_stray_ack_valid", {31'b0, inst_valid}, 32'h1);

        // Branch to 0x40
        commit   = 1'b1;
        pcsource = 2'b01;
        bpc      = 32'h0000_0040;
        step();
        commit = 1'b0;
        check("t3_br_addr", imem.addr, 32'h40);
        check("t3_br_req", {31'b0, imem.req}, 32'h1);
        check("t3_br_retired", retired, 32'h1);
        check("t3_br_valid", {31'b0, inst_valid}, 32'h0);

        // Stray commit while FETCH (first wait cycle)
        commit   = 1'b1;
        pcsource = 2'b11;
        jpc      = 32'h0000_0200;
        step();
        commit = 1'b0;
        check("t6_stray_commit_pc", pc, 32'h40);
        check("t6_stray_commit_retired", retired, 32'h1);
        check("t6_stray_commit_inst", inst, 32'h2008_0005);

        // Remaining wait cycles: request and address held
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_req", {31'b0, imem.req}, 32'h1);
            check("t2_wait_addr", imem.addr, 32'h40);
            check("t2_wait_valid", {31'b0, inst_valid}, 32'h0);
            step();
        end
        imem.ack   = 1'b1;
        imem.rdata = 32'h8C09_0004;
        step();
        imem.ack = 1'b0;
        check("t2_valid", {31'b0, inst_valid}, 32'h1);
        check("t2_inst", inst, 32'h8C09_0004);
        check("t2_pc4", pc4, 32'h44);

        // jr to 0x80
        commit   = 1'b1;
        pcsource = 2'b10;
        rpc      = 32'h0000_0080;
        step();
        commit = 1'b0;
        check("t3_jr_addr", imem.addr, 32'h80);
        check("t3_jr_retired", retired, 32'h2);
        imem.ack   = 1'b1;
        imem.rdata = 32'h03E0_0008;
        step();
        imem.ack = 1'b0;
        check("t3_jr_inst", inst, 32'h03E0_0008);

        // j to 0x100
        commit   = 1'b1;
        pcsource = 2'b11;
        jpc      = 32'h0000_0100;
        step();
        commit = 1'b0;
        check("t3_j_addr", imem.addr, 32'h100);
        check("t3_j_retired", retired, 32'h3);
        imem.ack   = 1'b1;
        imem.rdata = 32'h0800_0000;
        step();
        imem.ack = 1'b0;

        // Jump to the top word: pc4 wraps to zero
        commit   = 1'b1;
        pcsource = 2'b11;
        jpc      = 32'hFFFF_FFFC;
        step();
        commit = 1'b0;
        check("wrap_addr", imem.addr, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0);
        imem.ack   = 1'b1;
        imem.rdata = 32'h0000_0000;
        step();
        imem.ack = 1'b0;
        check("wrap_misalign", {31'b0, misalign}, 32'h0);

        // Sequential fall-through wraps to address 0
        commit   = 1'b1;
        pcsource = 2'b00;
        step();
        commit = 1'b0;
        check("seq_wrap_addr", imem.addr, 32'h0);
        check("seq_wrap_retired", retired, 32'h5);
        imem.ack   = 1'b1;
        imem.rdata = 32'h1111_2222;
        step();
        imem.ack = 1'b0;

        // Misaligned jr target halts
        commit   = 1'b1;
        pcsource = 2'b10;
        rpc      = 32'h0000_0082;
        step();
        commit = 1'b0;
        check("t4_misalign", {31'b0, misalign}, 32'h1);
        check("t4_req", {31'b0, imem.req}, 32'h0);
        check("t4_valid", {31'b0, inst_valid}, 32'h0);
        check("t4_pc", pc, 32'h0);
        check("t4_retired", retired, 32'h6);

        imem.ack   = 1'b1;
        imem.rdata = 32'hCAFE_F00D;
        commit     = 1'b1;
        pcsource   = 2'b01;
        bpc        = 32'h0000_0040;
        step();
        step();
        imem.ack = 1'b0;
        commit   = 1'b0;
        check("t4_halt_req", {31'b0, imem.req}, 32'h0);
        check("t4_halt_inst", inst, 32'h1111_2222);
        check("t4_halt_retired", retired, 32'h6);
        check("t4_halt_pc", pc, 32'h0);
        check("t4_halt_valid", {31'b0, inst_valid}, 32'h0);

        // Reset out of HALT, then reset again while FETCH is pending
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_misalign_clr", {31'b0, misalign}, 32'h0);
        check("t5_retired_clr", retired, 32'h0);
        step();
        check("t5_fetch_req", {31'b0, imem.req}, 32'h1);
        reset = 1'b1;
        step();
        check("t5_req_drop", {31'b0, imem.req}, 32'h0);
        reset      = 1'b0;
        imem.ack   = 1'b1;
        imem.rdata = 32'h1234_5678;
        step();
        imem.ack = 1'b0;
        check("t5_late_ack_inst", inst, 32'h0);
        check("t5_late_ack_valid", {31'b0, inst_valid}, 32'h0);
        check("t5_restart_req", {31'b0, imem.req}, 32'h1);
        check("t5_restart_addr", imem.addr, 32'h0);
        imem.ack   = 1'b1;
        imem.rdata = 32'h2008_0005;
        step();
        imem.ack = 1'b0;
        check("t5_refetch_inst", inst, 32'h2008_0005);
        check("t5_refetch_valid", {31'b0, inst_valid}, 32'h1);

        // Reset wins over a same-cycle commit
        reset    = 1'b1;
        commit   = 1'b1;
        pcsource = 2'b01;
        bpc      = 32'h0000_0040;
        step();
        reset  = 1'b0;
        commit = 1'b0;
        check("rst_prio_pc", pc, 32'h0);
        check("rst_prio_retired", retired, 32'h0);
        check("rst_prio_inst", inst, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
